// File: rtl/id_ex_pipe_reg_pkg.sv
// ID/EX pipeline register shared types.
// ALU op encodings, zero-register index and the control bundle.
package id_ex_pkg;

    localparam int ALUOP_W_DEF = 3;
    localparam int ZR_IDX_DEF  = 31;

    typedef enum logic [ALUOP_W_DEF-1:0] {
        ALU_AND   = 3'd0,
        ALU_ORR   = 3'd1,
        ALU_ADD   = 3'd2,
        ALU_SUB   = 3'd6,
        ALU_PASSB = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic                   alu_src;
        logic [ALUOP_W_DEF-1:0] alu_op;
        logic                   mem_read;
        logic                   mem_write;
        logic                   mem_to_reg;
        logic                   reg_write;
    } ctrl_t;

    // Zero the whole bundle when the slot must not act.
    function automatic ctrl_t gate_ctrl(ctrl_t c, logic en);
        return en ? c : '0;
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX register.
// master: decode/execute neighbours; slave: the pipeline register.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W  = 64,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3
);
    logic               Valid_De;
    logic               ALUSrc_De;
    logic [ALUOP_W-1:0] ALUOp_De;
    logic               MemRead_De;
    logic               MemWrite_De;
    logic               MemtoReg_De;
    logic               RegWrite_De;
    logic               UsesRm_De;
    logic [REG_W-1:0]   Rd_De;
    logic [REG_W-1:0]   Rn_De;
    logic [REG_W-1:0]   Rm_De;
    logic [DATA_W-1:0]  SignExt_De;
    logic [DATA_W-1:0]  ReadData1_De;
    logic [DATA_W-1:0]  ReadData2_De;
    logic [DATA_W-1:0]  PC_De;

    logic               Valid_Ex;
    logic               ALUSrc_Ex;
    logic [ALUOP_W-1:0] ALUOp_Ex;
    logic               MemRead_Ex;
    logic               MemWrite_Ex;
    logic               MemtoReg_Ex;
    logic               RegWrite_Ex;
    logic [REG_W-1:0]   Rd_Ex;
    logic [REG_W-1:0]   Rn_Ex;
    logic [REG_W-1:0]   Rm_Ex;
    logic [DATA_W-1:0]  SignExt_Ex;
    logic [DATA_W-1:0]  ReadData1_Ex;
    logic [DATA_W-1:0]  ReadData2_Ex;
    logic [DATA_W-1:0]  PC_Ex;

    modport master (
        output Valid_De, ALUSrc_De, ALUOp_De, MemRead_De,
               MemWrite_De, MemtoReg_De, RegWrite_De, UsesRm_De,
               Rd_De, Rn_De, Rm_De, SignExt_De, ReadData1_De,
               ReadData2_De, PC_De,
        input  Valid_Ex, ALUSrc_Ex, ALUOp_Ex, MemRead_Ex,
               MemWrite_Ex, MemtoReg_Ex, RegWrite_Ex,
               Rd_Ex, Rn_Ex, Rm_Ex, SignExt_Ex, ReadData1_Ex,
               ReadData2_Ex, PC_Ex
    );

    modport slave (
        input  Valid_De, ALUSrc_De, ALUOp_De, MemRead_De,
               MemWrite_De, MemtoReg_De, RegWrite_De, UsesRm_De,
               Rd_De, Rn_De, Rm_De, SignExt_De, ReadData1_De,
               ReadData2_De, PC_De,
        output Valid_Ex, ALUSrc_Ex, ALUOp_Ex, MemRead_Ex,
               MemWrite_Ex, MemtoReg_Ex, RegWrite_Ex,
               Rd_Ex, Rn_Ex, Rm_Ex, SignExt_Ex, ReadData1_Ex,
               ReadData2_Ex, PC_Ex
    );
endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use match between the Ex load and the decode slot.
// Ports: ex_* (load in Ex), de_* (decode sources), lu (hazard).
module load_use_detect #(
    parameter int REG_W  = 5,
    parameter int ZR_IDX = 31
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             de_valid,
    input  logic             de_uses_rm,
    input  logic [REG_W-1:0] de_rn,
    input  logic [REG_W-1:0] de_rm,
    output logic             lu
);
    localparam logic [REG_W-1:0] ZR = REG_W'(ZR_IDX);

    logic rn_hit;
    logic rm_hit;

    assign rn_hit = (ex_rd == de_rn);
    assign rm_hit = de_uses_rm & (ex_rd == de_rm);

    // XZR reads as zero, so a load targeting it feeds nobody.
    assign lu = ex_valid & ex_mem_read & de_valid &
                (ex_rd != ZR) & (rn_hit | rm_hit);
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush, load-use bubbles and a
// saturating bubble counter. Ports: clk/Reset, bus (De in, Ex out),
// Stall/Flush/ClrCnt controls, HazardStall and BubbleCnt status.
module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int ZR_IDX  = ZR_IDX_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             Reset,
    id_ex_pipe_reg_if.slave  bus,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             ClrCnt,
    output logic             HazardStall,
    output logic [CNT_W-1:0] BubbleCnt
);
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_de;
    logic              valid_q;
    logic [REG_W-1:0]  rd_q;
    logic [REG_W-1:0]  rn_q;
    logic [REG_W-1:0]  rm_q;
    logic [DATA_W-1:0] se_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] pc_q;
    logic [CNT_W-1:0]  cnt_q;

    logic lu;
    logic bubble;
    logic load;

    load_use_detect #(
        .REG_W  (REG_W),
        .ZR_IDX (ZR_IDX)
    ) u_lu (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .de_valid    (bus.Valid_De),
        .de_uses_rm  (bus.UsesRm_De),
        .de_rn       (bus.Rn_De),
        .de_rm       (bus.Rm_De),
        .lu          (lu)
    );

    assign ctrl_de = '{
        alu_src:    bus.ALUSrc_De,
        alu_op:     bus.ALUOp_De,
        mem_read:   bus.MemRead_De,
        mem_write:  bus.MemWrite_De,
        mem_to_reg: bus.MemtoReg_De,
        reg_write:  bus.RegWrite_De
    };

    // Flush overrides Stall; a load-use bubble only when not stalled.
    assign bubble      = Flush | (lu & ~Stall);
    assign load        = Flush | ~Stall;
    assign HazardStall = lu & ~Flush & ~Stall;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            se_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            pc_q    <= '0;
        end else if (load) begin
            valid_q <= bus.Valid_De & ~bubble;
            ctrl_q  <= gate_ctrl(ctrl_de, bus.Valid_De & ~bubble);
            rd_q    <= bus.Rd_De;
            rn_q    <= bus.Rn_De;
            rm_q    <= bus.Rm_De;
            se_q    <= bus.SignExt_De;
            rd1_q   <= bus.ReadData1_De;
            rd2_q   <= bus.ReadData2_De;
            pc_q    <= bus.PC_De;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (ClrCnt) begin
            cnt_q <= '0;
        end else if (bubble && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign BubbleCnt        = cnt_q;
    assign bus.Valid_Ex     = valid_q;
    assign bus.ALUSrc_Ex    = ctrl_q.alu_src;
    assign bus.ALUOp_Ex     = ctrl_q.alu_op;
    assign bus.MemRead_Ex   = ctrl_q.mem_read;
    assign bus.MemWrite_Ex  = ctrl_q.mem_write;
    assign bus.MemtoReg_Ex  = ctrl_q.mem_to_reg;
    assign bus.RegWrite_Ex  = ctrl_q.reg_write;
    assign bus.Rd_Ex        = rd_q;
    assign bus.Rn_Ex        = rn_q;
    assign bus.Rm_Ex        = rm_q;
    assign bus.SignExt_Ex   = se_q;
    assign bus.ReadData1_Ex = rd1_q;
    assign bus.ReadData2_Ex = rd2_q;
    assign bus.PC_Ex        = pc_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table plus reset/saturation sequences.
// Expected Ex state is queued at drive time and checked after the edge.
module tb_id_ex_pipe_reg;
    import id_ex_pkg::*;

    typedef struct {
        logic        v, mr, rw, urm, st, fl, clr;
        logic [4:0]  rd, rn, rm;
        logic [63:0] pc;
        logic        hz, v_ex, mr_ex, rw_ex;
        logic [4:0]  rd_ex;
        logic [63:0] pc_ex;
        logic [3:0]  cnt;
    } vec_t;

    typedef struct {
        logic        v_ex, mr_ex, rw_ex;
        logic [4:0]  rd_ex;
        logic [63:0] pc_ex;
        logic [3:0]  cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Stall, Flush, ClrCnt;
    logic       HazardStall;
    logic [3:0] BubbleCnt;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];
    vec_t tab[$];

    id_ex_pipe_reg_if #(.DATA_W(64), .REG_W(5), .ALUOP_W(3)) bus ();

    id_ex_pipe_reg #(.CNT_W(4)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .bus         (bus),
        .Stall       (Stall),
        .Flush       (Flush),
        .ClrCnt      (ClrCnt),
        .HazardStall (HazardStall),
        .BubbleCnt   (BubbleCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        logic v, logic mr, logic rw, logic urm,
        logic st, logic fl, logic clr,
        logic [4:0] rd, logic [4:0] rn, logic [4:0] rm,
        logic [63:0] pc, logic hz, logic v_ex, logic mr_ex,
        logic rw_ex, logic [4:0] rd_ex, logic [63:0] pc_ex,
        logic [3:0] cnt);
        vec_t t;
        t.v = v; t.mr = mr; t.rw = rw; t.urm = urm;
        t.st = st; t.fl = fl; t.clr = clr;
        t.rd = rd; t.rn = rn; t.rm = rm; t.pc = pc;
        t.hz = hz; t.v_ex = v_ex; t.mr_ex = mr_ex;
        t.rw_ex = rw_ex; t.rd_ex = rd_ex; t.pc_ex = pc_ex;
        t.cnt = cnt;
        return t;
    endfunction

    task automatic drive(vec_t t);
        bus.Valid_De     = t.v;
        bus.MemRead_De   = t.mr;
        bus.MemtoReg_De  = t.mr;
        bus.RegWrite_De  = t.rw;
        bus.UsesRm_De    = t.urm;
        bus.Rd_De        = t.rd;
        bus.Rn_De        = t.rn;
        bus.Rm_De        = t.rm;
        bus.PC_De        = t.pc;
        bus.ReadData1_De = t.pc ^ 64'hA5;
        Stall            = t.st;
        Flush            = t.fl;
        ClrCnt           = t.clr;
    endtask

    task automatic apply(vec_t t, int idx);
        exp_t e;
        exp_t g;
        @(negedge clk);
        drive(t);
        #1;
        chk($sformatf("hz[%0d]", idx), 64'(HazardStall), 64'(t.hz));
        e.v_ex = t.v_ex; e.mr_ex = t.mr_ex; e.rw_ex = t.rw_ex;
        e.rd_ex = t.rd_ex; e.pc_ex = t.pc_ex; e.cnt = t.cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", idx), 64'd0, 64'd1);
        end else begin
            g = sb.pop_front();
            chk($sformatf("v_ex[%0d]", idx),
                64'(bus.Valid_Ex), 64'(g.v_ex));
            chk($sformatf("mr_ex[%0d]", idx),
                64'(bus.MemRead_Ex), 64'(g.mr_ex));
            chk($sformatf("rw_ex[%0d]", idx),
                64'(bus.RegWrite_Ex), 64'(g.rw_ex));
            chk($sformatf("rd_ex[%0d]", idx),
                64'(bus.Rd_Ex), 64'(g.rd_ex));
            chk($sformatf("pc_ex[%0d]", idx), bus.PC_Ex, g.pc_ex);
            chk($sformatf("rd1_ex[%0d]", idx),
                bus.ReadData1_Ex, g.pc_ex ^ 64'hA5);
            chk($sformatf("cnt[%0d]", idx),
                64'(BubbleCnt), 64'(g.cnt));
        end
    endtask

    initial begin
        vec_t z;
        z = mk(0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0, 0,0, 0);
        drive(z);
        bus.ALUSrc_De    = 1'b0;
        bus.ALUOp_De     = ALU_ADD;
        bus.MemWrite_De  = 1'b0;
        bus.SignExt_De   = 64'h10;
        bus.ReadData2_De = 64'h20;
        Reset = 1'b1;

        //    v mr rw urm st fl clr rd rn rm pc  hz v mr rw rd pc cnt
        tab.push_back(mk(1,0,1,1, 0,0,0, 20,30,31, 3,  0, 1,0,1, 20, 3, 0));
        tab.push_back(mk(1,1,1,0, 0,0,0,  5, 1, 0, 4,  0, 1,1,1,  5, 4, 0));
        tab.push_back(mk(1,0,1,1, 0,0,0,  6, 5, 2, 8,  1, 0,0,0,  6, 8, 1));
        tab.push_back(mk(1,0,1,1, 0,0,0,  6, 5, 2, 8,  0, 1,0,1,  6, 8, 1));
        tab.push_back(mk(1,1,1,0, 0,0,0, 31, 2, 0, 12, 0, 1,1,1, 31,12, 1));
        tab.push_back(mk(1,0,1,1, 0,0,0,  3,31,31, 16, 0, 1,0,1,  3,16, 1));
        tab.push_back(mk(1,1,1,0, 0,0,0,  7, 1, 0, 20, 0, 1,1,1,  7,20, 1));
        tab.push_back(mk(1,0,0,0, 0,0,0,  9, 2, 7, 24, 0, 1,0,0,  9,24, 1));
        tab.push_back(mk(1,1,1,0, 0,0,0,  7, 1, 0, 28, 0, 1,1,1,  7,28, 1));
        tab.push_back(mk(1,0,1,1, 0,0,0, 10, 1, 7, 32, 1, 0,0,0, 10,32, 2));
        tab.push_back(mk(1,0,1,1, 0,0,0, 10, 1, 7, 32, 0, 1,0,1, 10,32, 2));
        tab.push_back(mk(0,1,1,0, 0,0,0, 11, 1, 0, 36, 0, 0,0,0, 11,36, 2));
        tab.push_back(mk(1,0,1,0, 0,0,0, 12,11, 0, 40, 0, 1,0,1, 12,40, 2));
        tab.push_back(mk(1,1,1,0, 0,0,0,  5, 1, 0, 44, 0, 1,1,1,  5,44, 2));
        tab.push_back(mk(1,0,1,0, 1,0,0, 13, 5, 0, 48, 0, 1,1,1,  5,44, 2));
        tab.push_back(mk(1,0,1,0, 1,0,0, 13, 5, 0, 48, 0, 1,1,1,  5,44, 2));
        tab.push_back(mk(1,0,1,0, 1,0,0, 13, 5, 0, 48, 0, 1,1,1,  5,44, 2));
        tab.push_back(mk(1,0,1,0, 0,1,0, 13, 5, 0, 48, 0, 0,0,0, 13,48, 3));

        #12;
        chk("rst_valid", 64'(bus.Valid_Ex), 64'd0);
        chk("rst_pc", bus.PC_Ex, 64'd0);
        chk("rst_cnt", 64'(BubbleCnt), 64'd0);
        chk("rst_hz", 64'(HazardStall), 64'd0);
        @(negedge clk);
        Reset = 1'b0;

        for (int i = 0; i < tab.size(); i++) begin
            apply(tab[i], i);
            if (i == 0) begin
                chk("add_rn", 64'(bus.Rn_Ex), 64'd30);
                chk("add_rm", 64'(bus.Rm_Ex), 64'd31);
            end
        end

        // Reset mid-stall with a valid load in Ex.
        apply(mk(1,1,1,0, 0,0,0, 5,1,0, 52, 0, 1,1,1, 5,52, 3), 100);
        @(negedge clk);
        drive(mk(1,0,1,0, 1,0,0, 13,5,0, 56, 0,0,0,0, 0,0, 0));
        #1;
        chk("stall_hz", 64'(HazardStall), 64'd0);
        #1;
        Reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.Valid_Ex), 64'd0);
        chk("mid_rst_mr", 64'(bus.MemRead_Ex), 64'd0);
        chk("mid_rst_rd", 64'(bus.Rd_Ex), 64'd0);
        chk("mid_rst_pc", bus.PC_Ex, 64'd0);
        chk("mid_rst_cnt", 64'(BubbleCnt), 64'd0);
        chk("mid_rst_hz", 64'(HazardStall), 64'd0);
        @(negedge clk);
        Reset = 1'b0;

        // Twenty flushes saturate the 4-bit counter at 15.
        for (int i = 0; i < 20; i++) begin
            int c;
            c = (i + 1 > 15) ? 15 : i + 1;
            apply(mk(1,1,1,0, 0,1,0, 1,2,3, 64'(60 + i),
                     0, 0,0,0, 1, 64'(60 + i), 4'(c)), 200 + i);
        end
        apply(mk(1,0,1,0, 0,1,1, 2,3,4, 90, 0, 0,0,0, 2,90, 0), 300);
        apply(mk(1,0,1,0, 0,0,0, 4,3,2, 94, 0, 1,0,1, 4,94, 0), 301);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
